tdm_demux_4ch: RTL
==================

# tdm_demux_4ch

Receive end of the 4-channel time-division link: takes the single-wire serial stream built by selecting four sources in rotation, slot by slot, and rebuilds the four channel words. Frame sync locates slot 0; each frame carries one bit per channel; after W frames the four W-bit words are presented in parallel with a one-cycle valid strobe. Sits after the line receiver, ahead of per-channel consumers.

## Interface
- W, 4: bits per channel word, MSB first; legal range 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  slot strobe; d and fs are sampled only when en=1.
- d  in  1  serial data bit for the current slot.
- fs  in  1  frame sync; 1 exactly on the slot-0 bit.
- y0, y1, y2, y3  out  W  last complete word of channel 0..3, registered.
- valid  out  1  one-cycle pulse when y0..y3 update.
- locked  out  1  1 while the state machine is in LOCK.
- sync_err  out  1  one-cycle pulse on a framing violation.
- err_cnt  out  8  saturating framing-error count (only with TDM_DEMUX_ERRCNT_EN).

## Operation
- Reset: state=HUNT; slot=0; bit=0; shift regs, y0..y3=0; valid=0; locked=0; sync_err=0; err_cnt=0.
- Internal: 2-bit slot counter, bit counter 0..W-1, four W-bit shift regs sr0..sr3.
- en=0: no state change; valid and sync_err are 0 next cycle.
- HUNT, en=1, fs=0: bit ignored, stay.
- HUNT, en=1, fs=1: sr0 <= {sr0[W-2:0], d}; slot=1; bit=0; go LOCK.
- LOCK, en=1, legal slot (fs=1 iff slot=0): sr[slot] <= {sr[slot][W-2:0], d}; slot increments, wrapping 3->0. When slot=3: bit increments; at bit=W-1 it wraps to 0 and y0..y2 <= sr0..sr2, y3 <= {sr3[W-2:0], d}; valid=1 next cycle.
- LOCK, en=1, fs=1 at slot!=0 (early sync): sync_err=1; all partial words discarded; that bit is taken as slot 0, bit 0 of a new word (sr0 loaded, slot=1, bit=0); stay LOCK.
- LOCK, en=1, fs=0 at slot=0 (missing sync): sync_err=1; partial words discarded; bit ignored; slot=0, bit=0; go HUNT.
- y0..y3 hold between valid pulses; never modified by a sync error.
- Simultaneous word completion and error is impossible (completion requires slot=3, fs=0, which is legal).

## Timing
- All outputs registered; updates one clk after the sampling en cycle.
- Latency: valid and new y appear the cycle after the en cycle carrying channel-3 bit W-1.
- First valid after lock: 4*W en-cycles after the first accepted fs (inclusive).
- locked rises the cycle after the accepted fs; falls the cycle after a missing-sync error.
- Async reset mid-word: outputs clear immediately; partial data lost; resume in HUNT.
- Back-to-back en supported; no minimum gap.

## Configuration
- TDM_DEMUX_ERRCNT_EN defined: port err_cnt present; increments by 1 on each sync_err pulse, same cycle; saturates at 255; cleared only by reset.
- Undefined: err_cnt port and counter absent; all other behaviour identical.

## Test plan
- Reset, then en=1 continuous, 4 clean frames, W=4, channel words A,5,3,C -> one valid pulse; y0=4'hA, y1=4'h5, y2=4'h3, y3=4'hC; locked=1; sync_err never.
- Stream with fs=0 for 7 slots before first fs -> bits ignored, locked=0 until fs, first valid exactly 16 en-cycles after fs.
- en toggled 1/0 every other cycle on the clean-frame stream -> same words, valid delayed accordingly, no spurious pulses during en=0.
- fs asserted at slot 2 mid-word -> sync_err pulse, y unchanged, new word assembly starts; next valid 16 en-cycles later with correct data.
- fs missing at slot 0 -> sync_err, locked=0, HUNT; re-lock on next fs; with macro err_cnt=1, and 300 forced errors -> err_cnt=255.
- rst_n pulsed low at slot 2, frame 3 -> all outputs 0 immediately, locked=0, no valid until a full 16-slot word after next fs.

Source files
------------

// File: rtl/tdm_demux_4ch.sv
// Purpose : receive end of a 4-channel TDM link; rebuilds four W-bit channel words
//           from a one-bit-per-slot serial stream aligned by a slot-0 frame sync.
// Latency : all outputs registered, one clk after the sampling en cycle.
// Backpr. : none; the upstream slot strobe en paces the block, and en=0 freezes it.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   en, d, fs             slot strobe, serial data bit, frame sync (slot 0 marker)
//   y0..y3                last complete word of channel 0..3 (MSB first)
//   valid                 one-cycle pulse when y0..y3 update
//   locked                high while in LOCK
//   sync_err              one-cycle pulse on a framing violation
//   err_cnt               saturating framing-error count; present only when the
//                         macro TDM_DEMUX_ERRCNT_EN is defined
module tdm_demux_4ch #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         d,
    input  logic         fs,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         valid,
    output logic         locked,
    output logic         sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t          r_state;
    logic [1:0]      r_slot;
    logic [BW-1:0]   r_bit;
    logic [W-1:0]    r_sr [4];
    logic [W-1:0]    r_y0, r_y1, r_y2, r_y3;
    logic            r_valid;
    logic            r_locked;
    logic            r_sync_err;

    // Framing violations are only defined while locked.
    logic w_early;
    logic w_miss;
    logic w_err;

    assign w_early = en && (r_state == LOCK) &&  fs && (r_slot != 2'd0);
    assign w_miss  = en && (r_state == LOCK) && !fs && (r_slot == 2'd0);
    assign w_err   = w_early || w_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_slot     <= 2'd0;
            r_bit      <= '0;
            for (int i = 0; i < 4; i++) r_sr[i] <= '0;
            r_y0       <= '0;
            r_y1       <= '0;
            r_y2       <= '0;
            r_y3       <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
            if (en) begin
                case (r_state)
                    HUNT: begin
                        if (fs) begin
                            r_sr[0]  <= {r_sr[0][W-2:0], d};
                            r_slot   <= 2'd1;
                            r_bit    <= '0;
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end
                    end
                    LOCK: begin
                        if (w_early) begin
                            // Resynchronise on the unexpected sync: this bit opens a new word.
                            r_sync_err <= 1'b1;
                            r_sr[0]    <= {{(W-1){1'b0}}, d};
                            r_sr[1]    <= '0;
                            r_sr[2]    <= '0;
                            r_sr[3]    <= '0;
                            r_slot     <= 2'd1;
                            r_bit      <= '0;
                        end else if (w_miss) begin
                            r_sync_err <= 1'b1;
                            for (int i = 0; i < 4; i++) r_sr[i] <= '0;
                            r_slot     <= 2'd0;
                            r_bit      <= '0;
                            r_state    <= HUNT;
                            r_locked   <= 1'b0;
                        end else begin
                            r_sr[r_slot] <= {r_sr[r_slot][W-2:0], d};
                            r_slot       <= r_slot + 2'd1;
                            if (r_slot == 2'd3) begin
                                if (r_bit == LAST_BIT) begin
                                    // Channel 3's last bit is still arriving on d, so
                                    // its word is taken straight from the shifter input.
                                    r_bit   <= '0;
                                    r_y0    <= r_sr[0];
                                    r_y1    <= r_sr[1];
                                    r_y2    <= r_sr[2];
                                    r_y3    <= {r_sr[3][W-2:0], d};
                                    r_valid <= 1'b1;
                                end else begin
                                    r_bit <= r_bit + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign y0       = r_y0;
    assign y1       = r_y1;
    assign y2       = r_y2;
    assign y3       = r_y3;
    assign valid    = r_valid;
    assign locked   = r_locked;
    assign sync_err = r_sync_err;

endmodule
